// File: rtl/serial_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deframer
//  Description : Receive side of the single-bit serial link. Samples one bit
//                per clock on data_in and rebuilds framed words:
//                  start(0) | WIDTH data bits LSB-first | [even parity] | stop(1)
//                The line idles high. Good words go to a valid/ready output
//                register. Bad frames and dropped frames raise one-cycle
//                error pulses.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      data bits per frame (2..32)
//    PARITY_EN  1 = even-parity bit follows the data, 0 = no parity bit
//  Ports
//    clk        in   1      clock, rising edge
//    rst        in   1      synchronous reset, active-high
//    data_in    in   1      serial line, idle high
//    data_out   out  WIDTH  received word, stable while out_valid=1
//    out_valid  out  1      data_out holds an unconsumed word
//    out_ready  in   1      consumer takes the word on out_valid && out_ready
//    parity_err out  1      pulse: frame dropped on parity mismatch
//    frame_err  out  1      pulse: frame dropped because the stop bit was 0
//    overrun    out  1      pulse: good frame dropped, output register full
// ============================================================================
module serial_deframer #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int               c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_par;       // running XOR of the data bits
  logic               r_par_bad;   // latched parity verdict for the stop stage
  logic [WIDTH-1:0]   r_data;
  logic               r_out_valid;
  logic               r_parity_err;
  logic               r_frame_err;
  logic               r_overrun;

  logic               w_par_bad;
  logic               w_can_load;

  // Without a parity bit the check can never fail.
  assign w_par_bad  = PARITY_EN && r_par_bad;
  // A new word may enter if the register is empty or is being drained now.
  assign w_can_load = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_par_bad    <= 1'b0;
      r_data       <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses.
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;

      // Consumption; a good frame completing on this edge overrides below.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!data_in) begin
            r_state   <= ST_DATA;
            r_cnt     <= '0;
            r_par     <= 1'b0;
            r_par_bad <= 1'b0;
          end
        end

        ST_DATA: begin
          // Shift right: the first data bit ends up in bit 0.
          r_shift <= {data_in, r_shift[WIDTH-1:1]};
          r_par   <= r_par ^ data_in;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_BIT) begin
            r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end

        ST_PARITY: begin
          r_par_bad <= r_par ^ data_in;
          r_state   <= ST_STOP;
        end

        ST_STOP: begin
          if (data_in) begin
            r_state <= ST_IDLE;
            if (w_par_bad) begin
              r_parity_err <= 1'b1;
            end else if (w_can_load) begin
              r_data      <= r_shift;
              r_out_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_state      <= ST_BREAK;
            r_frame_err  <= 1'b1;
            r_parity_err <= w_par_bad;
          end
        end

        ST_BREAK: begin
          // The line must be seen high before another start bit counts.
          if (data_in) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deframer
//  Description : Directed self-checking bench for serial_deframer. One
//                instance has parity enabled, the other has it disabled.
//                Inputs change 1 time unit after each rising edge, and outputs
//                are checked at that same point.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_deframer;

  logic       clk;
  logic       rst;

  logic       data_in;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  logic       data_in_np;
  logic [7:0] data_out_np;
  logic       out_valid_np;
  logic       out_ready_np;
  logic       parity_err_np;
  logic       frame_err_np;
  logic       overrun_np;

  int n_vec;
  int n_err;

  serial_deframer #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  serial_deframer #(.WIDTH(8), .PARITY_EN(1'b0)) dut_np (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in_np),
    .data_out   (data_out_np),
    .out_valid  (out_valid_np),
    .out_ready  (out_ready_np),
    .parity_err (parity_err_np),
    .frame_err  (frame_err_np),
    .overrun    (overrun_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bit on the parity-enabled line, clock it in, and settle.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit_np(input logic b);
    data_in_np = b;
    @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, even parity (optionally inverted).
  // The stop bit is sent by the caller so that it can check that edge.
  task automatic body(input logic [7:0] d, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
  endtask

  task automatic chk_errs(input string tag, input logic pe, input logic fe, input logic ov);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, {31'd0, pe});
    chk({tag, "_frame_err"},  {31'd0, frame_err},  {31'd0, fe});
    chk({tag, "_overrun"},    {31'd0, overrun},    {31'd0, ov});
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    data_in      = 1'b1;
    data_in_np   = 1'b1;
    out_ready    = 1'b1;
    out_ready_np = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // ---- reset state
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, data_out},  32'h00);
    chk_errs("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_np_valid", {31'd0, out_valid_np}, 32'd0);
    rst = 1'b0;
    send_bit(1'b1);

    // ---- case 1: 8'hA5, good parity; valid appears on the stop edge
    body(8'hA5, 1'b0);
    chk("c1_valid_before_stop", {31'd0, out_valid}, 32'd0);
    send_bit(1'b1);
    chk("c1_valid", {31'd0, out_valid}, 32'd1);
    chk("c1_data",  {24'd0, data_out},  32'hA5);
    chk_errs("c1", 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);
    chk("c1_consumed", {31'd0, out_valid}, 32'd0);
    chk("c1_data_kept", {24'd0, data_out}, 32'hA5);

    // ---- case 2: bad parity, then a good 8'h3C frame
    body(8'hA5, 1'b1);
    send_bit(1'b1);
    chk_errs("c2_bad", 1'b1, 1'b0, 1'b0);
    chk("c2_no_valid", {31'd0, out_valid}, 32'd0);
    send_bit(1'b1);
    chk("c2_pulse_end", {31'd0, parity_err}, 32'd0);
    body(8'h3C, 1'b0);
    send_bit(1'b1);
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_data",  {24'd0, data_out},  32'h3C);
    chk_errs("c2_good", 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);

    // ---- case 3: stop bit 0, line held low, then 8'h81
    body(8'h0F, 1'b0);
    send_bit(1'b0);
    chk_errs("c3_bad", 1'b0, 1'b1, 1'b0);
    chk("c3_no_valid", {31'd0, out_valid}, 32'd0);
    send_bit(1'b0);
    chk("c3_pulse_end", {31'd0, frame_err}, 32'd0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("c3_break_quiet", {31'd0, out_valid | frame_err}, 32'd0);
    send_bit(1'b1);
    body(8'h81, 1'b0);
    send_bit(1'b1);
    chk("c3_valid", {31'd0, out_valid}, 32'd1);
    chk("c3_data",  {24'd0, data_out},  32'h81);
    send_bit(1'b1);

    // ---- case 4: overrun with out_ready low, back-to-back frames
    out_ready = 1'b0;
    body(8'h11, 1'b0);
    send_bit(1'b1);
    chk("c4_valid1", {31'd0, out_valid}, 32'd1);
    chk("c4_data1",  {24'd0, data_out},  32'h11);
    body(8'h22, 1'b0);
    send_bit(1'b1);
    chk("c4_overrun", {31'd0, overrun}, 32'd1);
    chk("c4_data_held", {24'd0, data_out}, 32'h11);
    chk("c4_still_valid", {31'd0, out_valid}, 32'd1);
    send_bit(1'b1);
    chk("c4_overrun_end", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("c4_drained", {31'd0, out_valid}, 32'd0);
    chk("c4_data_kept", {24'd0, data_out}, 32'h11);

    // ---- case 5: consume 8'h55 on the edge that completes 8'hAA
    out_ready = 1'b0;
    body(8'h55, 1'b0);
    send_bit(1'b1);
    chk("c5_data55", {24'd0, data_out}, 32'h55);
    body(8'hAA, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("c5_valid", {31'd0, out_valid}, 32'd1);
    chk("c5_dataAA", {24'd0, data_out}, 32'hAA);
    chk("c5_no_overrun", {31'd0, overrun}, 32'd0);
    send_bit(1'b1);
    chk("c5_drained", {31'd0, out_valid}, 32'd0);

    // ---- case 6: reset mid-frame, then 8'hC3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    send_bit(1'b1);
    chk("c6_rst_data", {24'd0, data_out}, 32'h00);
    chk("c6_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    chk_errs("c6_quiet", 1'b0, 1'b0, 1'b0);
    chk("c6_quiet_valid", {31'd0, out_valid}, 32'd0);
    body(8'hC3, 1'b0);
    send_bit(1'b1);
    chk("c6_valid", {31'd0, out_valid}, 32'd1);
    chk("c6_data",  {24'd0, data_out},  32'hC3);
    chk_errs("c6", 1'b0, 1'b0, 1'b0);
    send_bit(1'b1);

    // ---- no-parity instance: stop bit directly after the data
    send_bit_np(1'b0);
    for (int i = 0; i < 8; i++) send_bit_np(i[0] ? 1'b0 : 1'b1);
    chk("np_valid_before_stop", {31'd0, out_valid_np}, 32'd0);
    send_bit_np(1'b1);
    chk("np_valid", {31'd0, out_valid_np}, 32'd1);
    chk("np_data",  {24'd0, data_out_np},  32'h55);
    chk("np_no_perr", {31'd0, parity_err_np | frame_err_np | overrun_np}, 32'd0);
    send_bit_np(1'b1);
    chk("np_consumed", {31'd0, out_valid_np}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
